register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: register and data-port width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 SHALL provide parameter SP_INIT, default 256: init value of registers 29 and 30, applied only to registers that exist.
REQ-004 SHALL provide parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-005 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL provide ports rd_a_addr and rd_b_addr  input  ADDR_W  read addresses, ports A and B.
REQ-008 SHALL provide ports rd_a_data and rd_b_data  output  DATA_W  read data, ports A and B.
REQ-009 SHALL provide ports rd_a_pend and rd_b_pend  output  1  pending-write flag for the addressed register.
REQ-010 SHALL provide ports wr0_en, wr0_addr, wr0_data  input  1/ADDR_W/DATA_W  write port 0.
REQ-011 SHALL provide ports wr1_en, wr1_addr, wr1_data  input  1/ADDR_W/DATA_W  write port 1.
REQ-012 SHALL provide ports pend_set and pend_addr  input  1/ADDR_W  mark a register as awaiting a write (load issued).
REQ-013 SHALL provide port ready  output  1  high when initialisation is complete and ports are live.

Function
REQ-014 SHALL implement a two-state controller, INIT and RUN, plus an ADDR_W-bit sweep pointer.
REQ-015 SHALL, in INIT, write each cycle the init value of register[ptr], clear pend[ptr], and increment ptr.
REQ-016 SHALL use these init values: register 1 = 1; registers 29 and 30 = SP_INIT; all others = 0.
REQ-017 SHALL go from INIT to RUN on the cycle after the write of register 2**ADDR_W-1; the sweep lasts exactly 2**ADDR_W cycles.
REQ-018 SHALL register ready: 0 in INIT, 1 in RUN.
REQ-019 SHALL, while ready=0, ignore wr0_en, wr1_en and pend_set, and force rd_*_data=0 and rd_*_pend=0.
REQ-020 SHALL make reads combinational: rd_x_data = register[rd_x_addr], with no clock latency.
REQ-021 SHALL accept write port N only when wrN_en=1, ready=1 and wrN_addr!=0; the register updates at the next rising edge.
REQ-022 SHALL, when both ports write the same address in the same cycle, store wr1_data (port 1 wins).
REQ-023 SHALL, with BYPASS=1, return the accepted write data of the same cycle when a read address matches it (wr1 over wr0); with BYPASS=0, return the stored value.
REQ-024 SHALL always read register 0 as 0, discard writes to it, and never set its pend bit.
REQ-025 SHALL hold one pend bit per register; pend_set with ready=1 and pend_addr!=0 sets pend[pend_addr] at the next edge.
REQ-026 SHALL clear pend[addr] at the next edge on any accepted write to addr.
REQ-027 SHALL, on pend_set and an accepted write to the same address in one cycle, leave the pend bit set (set wins).
REQ-028 SHALL drive rd_x_pend = pend[rd_x_addr] AND NOT (BYPASS=1 and an accepted write this cycle hits rd_x_addr).
REQ-029 SHALL never index outside the register array; the full 2**ADDR_W address space is valid.

Reset
REQ-030 SHALL, when rst=1 at an edge, enter INIT with ptr=0 and ready=0 at the next cycle, from any state.
REQ-031 SHALL, when rst is asserted mid-sweep, restart the sweep at ptr=0.
REQ-032 SHALL, when rst is asserted in RUN, restore all registers to their init values through a full sweep and clear all pend bits.
REQ-033 SHALL, while rst is held high, keep the controller in INIT at ptr=0 (the sweep does not advance).

Verification
REQ-034 SHALL cover: rst high 1 cycle then low -> ready=0 for 32 cycles, then 1; r1=1, r29=r30=256, r5=0.
REQ-035 SHALL cover: wr0 r5=0xDEADBEEF with rd_a_addr=5 in the same cycle -> rd_a_data=0xDEADBEEF that cycle (BYPASS=1) and on following cycles; with BYPASS=0, 0 in the same cycle.
REQ-036 SHALL cover: wr0 r7=0x11 and wr1 r7=0x22 in the same cycle -> r7=0x22; writing r0=0xFFFF and pend_set r0 -> rd_a_data=0 and rd_a_pend=0 on r0.
REQ-037 SHALL cover: pend_set r9 -> rd_a_pend=1 next cycle; a write to r9 -> rd_a_pend=0 the same cycle and after; pend_set and write r9 together -> pend stays 1.
REQ-038 SHALL cover: rst asserted at sweep cycle 10 -> ready remains 0 for 32 more cycles; rst in RUN after r5=0x55 -> ready 0 next cycle, then r5=0 and all pend=0.
REQ-039 SHALL cover: ADDR_W=4 (depth 16) -> 16-cycle sweep, SP_INIT not applied, r1=1, all others 0.

Source files
------------

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
//
// Multi-ported register file with two combinational read ports, two write
// ports, a per-register "pending write" scoreboard bit and a self-initialising
// sweep that loads every register with its power-on value after reset.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   rd_a_addr / rd_b_addr : read addresses (ports A and B)
//   rd_a_data / rd_b_data : combinational read data
//   rd_a_pend / rd_b_pend : pending-write flag of the addressed register
//   wr0_en/addr/data      : write port 0
//   wr1_en/addr/data      : write port 1 (wins over port 0 on the same address)
//   pend_set / pend_addr  : mark a register as awaiting a write (load issued)
//   ready                 : high once the init sweep has finished
//
// Parameters
//   DATA_W  : register width
//   ADDR_W  : address width, depth = 2**ADDR_W
//   SP_INIT : init value of registers 29 and 30 (only when they exist)
//   BYPASS  : 1 forwards same-cycle write data to the read ports
// -----------------------------------------------------------------------------
module register_file_mp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int SP_INIT = 256,
   parameter int BYPASS  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_a_addr,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_a_data,
   output logic [DATA_W-1:0] rd_b_data,
   output logic              rd_a_pend,
   output logic              rd_b_pend,
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic              pend_set,
   input  logic [ADDR_W-1:0] pend_addr,
   output logic              ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   // Registers 29/30 only exist when the file has at least 31 entries.
   localparam bit HAS_SP = (DEPTH > 30);
   localparam bit BYP_EN = (BYPASS != 0);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                ready_q, ready_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];
   logic [DEPTH-1:0]    pend_q, pend_d;

   logic                sweep_we;
   logic                wr0_acc, wr1_acc, pend_acc;

   // Power-on value of a register.
   function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] a);
      logic [31:0] ai;
      ai = 32'(a);
      init_value = '0;
      if (ai == 32'd1) begin
         init_value = DATA_W'(1);
      end else if (HAS_SP && (ai == 32'd29 || ai == 32'd30)) begin
         init_value = DATA_W'(SP_INIT);
      end
   endfunction

   // --------------------------------------------------------------------------
   // Controller: INIT sweeps every address once, then RUN forever.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ready_d = ready_q;
      unique case (state_q)
         ST_INIT: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == {ADDR_W{1'b1}}) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end
         end
         ST_RUN: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_INIT;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ready_q <= ready_d;
      end
   end

   assign ready = ready_q;

   // --------------------------------------------------------------------------
   // Write / pend acceptance. Address 0 is hard-wired, so it is never accepted.
   // --------------------------------------------------------------------------
   assign sweep_we = (state_q == ST_INIT) && !rst;
   assign wr0_acc  = ready_q && wr0_en   && (wr0_addr  != '0);
   assign wr1_acc  = ready_q && wr1_en   && (wr1_addr  != '0);
   assign pend_acc = ready_q && pend_set && (pend_addr != '0);

   // Order of assignment sets priority: port 1 after port 0 so it wins,
   // pend_set after the write-clear so a simultaneous set survives.
   always_comb begin
      mem_d  = mem_q;
      pend_d = pend_q;
      if (sweep_we) begin
         mem_d[ptr_q]  = init_value(ptr_q);
         pend_d[ptr_q] = 1'b0;
      end
      if (wr0_acc) begin
         mem_d[wr0_addr]  = wr0_data;
         pend_d[wr0_addr] = 1'b0;
      end
      if (wr1_acc) begin
         mem_d[wr1_addr]  = wr1_data;
         pend_d[wr1_addr] = 1'b0;
      end
      if (pend_acc) begin
         pend_d[pend_addr] = 1'b1;
      end
      mem_d[0]  = '0;
      pend_d[0] = 1'b0;
   end

   // Register contents are restored by the sweep, so they carry no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // --------------------------------------------------------------------------
   // Read ports, one identical slice per port.
   // --------------------------------------------------------------------------
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_pend [2];

   assign rd_addr[0] = rd_a_addr;
   assign rd_addr[1] = rd_b_addr;
   assign rd_a_data  = rd_data[0];
   assign rd_b_data  = rd_data[1];
   assign rd_a_pend  = rd_pend[0];
   assign rd_b_pend  = rd_pend[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic hit0, hit1;

         assign hit0 = BYP_EN && wr0_acc && (wr0_addr == rd_addr[gi]);
         assign hit1 = BYP_EN && wr1_acc && (wr1_addr == rd_addr[gi]);

         always_comb begin
            rd_data[gi] = '0;
            rd_pend[gi] = 1'b0;
            if (ready_q && (rd_addr[gi] != '0)) begin
               if (hit1) begin
                  rd_data[gi] = wr1_data;
               end else if (hit0) begin
                  rd_data[gi] = wr0_data;
               end else begin
                  rd_data[gi] = mem_q[rd_addr[gi]];
               end
               // A write landing this cycle resolves the pending load.
               rd_pend[gi] = pend_q[rd_addr[gi]] && !(hit0 || hit1);
            end
         end
      end
   endgenerate

endmodule
